stage_writeback: RTL and testbench

STAGE_WRITEBACK -- requirements
Module: stage_writeback

---
 rtl/core_pkg.sv | 35 +++
 rtl/stage_writeback_if.sv | 41 ++++
 rtl/load_align.sv | 40 ++++
 rtl/stage_writeback.sv | 126 ++++++++++++
 tb/tb_stage_writeback.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared codes, FSM states and widths for the writeback stage.
package core_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned SRC_W  = 2;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned OFF_W  = 2;
    localparam int unsigned CNT_W  = 32;

    // Result select codes
    localparam logic [SRC_W-1:0] RES_ALU       = 2'b00;
    localparam logic [SRC_W-1:0] RES_MEM       = 2'b01;
    localparam logic [SRC_W-1:0] RES_PC_PLUS   = 2'b10;
    localparam logic [SRC_W-1:0] RES_LUI_AUIPC = 2'b11;

    // Load width/sign codes
    localparam logic [F3_W-1:0] F3_LB  = 3'b000;
    localparam logic [F3_W-1:0] F3_LH  = 3'b001;
    localparam logic [F3_W-1:0] F3_LW  = 3'b010;
    localparam logic [F3_W-1:0] F3_LBU = 3'b100;
    localparam logic [F3_W-1:0] F3_LHU = 3'b101;

    // Writeback FSM states
    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] WAIT_MEM = 1'b1;

    // Context of a load waiting for its read data
    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [F3_W-1:0]  funct3;
        logic [OFF_W-1:0] off;
    } pend_load_t;

endpackage

// File: rtl/stage_writeback_if.sv
// Memory-stage to writeback-stage bus, plus the writeback result signals.
interface stage_writeback_if;
    import core_pkg::*;

    logic             mem_valid;
    logic [REG_W-1:0] mem_rd;
    logic             mem_regfile_wr_enable;
    logic [SRC_W-1:0] mem_result_src;
    logic [F3_W-1:0]  mem_funct3;
    logic [XLEN-1:0]  mem_alu_result;
    logic [XLEN-1:0]  mem_instr_addr_plus;
    logic [XLEN-1:0]  mem_lui_auipc_value;
    logic             dmem_rvalid;
    logic [XLEN-1:0]  dmem_rdata;

    logic [REG_W-1:0] wb_wr_addr;
    logic [XLEN-1:0]  wb_wr_data;
    logic             wb_regfile_wr_enable;
    logic             wb_stall;
    logic             wb_load_err;
    logic [CNT_W-1:0] wb_retire_count;

    // Upstream (memory stage / data memory) side
    modport master (
        output mem_valid, mem_rd, mem_regfile_wr_enable, mem_result_src,
               mem_funct3, mem_alu_result, mem_instr_addr_plus,
               mem_lui_auipc_value, dmem_rvalid, dmem_rdata,
        input  wb_wr_addr, wb_wr_data, wb_regfile_wr_enable, wb_stall,
               wb_load_err, wb_retire_count
    );

    // Writeback stage side
    modport slave (
        input  mem_valid, mem_rd, mem_regfile_wr_enable, mem_result_src,
               mem_funct3, mem_alu_result, mem_instr_addr_plus,
               mem_lui_auipc_value, dmem_rvalid, dmem_rdata,
        output wb_wr_addr, wb_wr_data, wb_regfile_wr_enable, wb_stall,
               wb_load_err, wb_retire_count
    );

endinterface

// File: rtl/load_align.sv
// Combinational load data extraction: byte/half/word select and extension.
module load_align
    import core_pkg::*;
(
    input  logic [F3_W-1:0]  funct3,
    input  logic [OFF_W-1:0] offset,
    input  logic [XLEN-1:0]  rdata,
    output logic [XLEN-1:0]  data,
    output logic             illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and half out of the read word
    always_comb begin
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extend according to the load code; unknown codes yield zero
    always_comb begin
        data    = '0;
        illegal = 1'b0;
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data = {16'd0, half_sel};
            F3_LW:   data = rdata;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/stage_writeback.sv
// Writeback stage: selects the result, completes loads (possibly after a
// wait for read data) and drives the register-file write port.
module stage_writeback
    import core_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    stage_writeback_if.slave   bus
);

    logic [0:0]       state_q, state_d;
    pend_load_t       pend_q, pend_d;

    logic [REG_W-1:0] wr_addr_q, wr_addr_d;
    logic [XLEN-1:0]  wr_data_q, wr_data_d;
    logic             wr_en_q, wr_en_d;
    logic             load_err_q, load_err_d;
    logic [CNT_W-1:0] retire_q, retire_d;

    logic             accept_c;
    logic             is_load_c;
    logic [F3_W-1:0]  al_funct3_c;
    logic [OFF_W-1:0] al_off_c;
    logic [XLEN-1:0]  al_data_c;
    logic             al_illegal_c;
    logic [XLEN-1:0]  nonload_data_c;

    assign accept_c  = bus.mem_valid && (state_q == IDLE);
    assign is_load_c = accept_c && (bus.mem_result_src == RES_MEM)
                       && bus.mem_regfile_wr_enable;

    // Aligner sees the live instruction in IDLE, the captured one while waiting
    assign al_funct3_c = (state_q == WAIT_MEM) ? pend_q.funct3 : bus.mem_funct3;
    assign al_off_c    = (state_q == WAIT_MEM) ? pend_q.off
                                               : bus.mem_alu_result[OFF_W-1:0];

    load_align u_load_align (
        .funct3  (al_funct3_c),
        .offset  (al_off_c),
        .rdata   (bus.dmem_rdata),
        .data    (al_data_c),
        .illegal (al_illegal_c)
    );

    // Non-load result select
    always_comb begin
        case (bus.mem_result_src)
            RES_PC_PLUS:   nonload_data_c = bus.mem_instr_addr_plus;
            RES_LUI_AUIPC: nonload_data_c = bus.mem_lui_auipc_value;
            default:       nonload_data_c = bus.mem_alu_result;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        load_err_d = 1'b0;
        retire_d   = retire_q;

        case (state_q)
            IDLE: begin
                if (accept_c && !is_load_c) begin
                    wr_addr_d = bus.mem_rd;
                    wr_data_d = nonload_data_c;
                    wr_en_d   = bus.mem_regfile_wr_enable && (bus.mem_rd != '0);
                    retire_d  = retire_q + CNT_W'(1);
                end else if (is_load_c && bus.dmem_rvalid) begin
                    wr_addr_d  = bus.mem_rd;
                    wr_data_d  = al_data_c;
                    wr_en_d    = (bus.mem_rd != '0);
                    load_err_d = al_illegal_c;
                    retire_d   = retire_q + CNT_W'(1);
                end else if (is_load_c) begin
                    pend_d.rd     = bus.mem_rd;
                    pend_d.funct3 = bus.mem_funct3;
                    pend_d.off    = bus.mem_alu_result[OFF_W-1:0];
                    state_d       = WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                if (bus.dmem_rvalid) begin
                    wr_addr_d  = pend_q.rd;
                    wr_data_d  = al_data_c;
                    wr_en_d    = (pend_q.rd != '0);
                    load_err_d = al_illegal_c;
                    retire_d   = retire_q + CNT_W'(1);
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any pending load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            load_err_q <= 1'b0;
            retire_q   <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            load_err_q <= load_err_d;
            retire_q   <= retire_d;
        end
    end

    assign bus.wb_wr_addr           = wr_addr_q;
    assign bus.wb_wr_data           = wr_data_q;
    assign bus.wb_regfile_wr_enable = wr_en_q;
    assign bus.wb_stall             = (state_q == WAIT_MEM);
    assign bus.wb_load_err          = load_err_q;
    assign bus.wb_retire_count      = retire_q;

endmodule

// File: tb/tb_stage_writeback.sv
// Directed bench for stage_writeback.
module tb_stage_writeback;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    logic [31:0] exp_count;

    stage_writeback_if bus ();

    stage_writeback dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [4:0] rd, input logic we,
                         input logic [1:0] src, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] pc,
                         input logic [31:0] lui, input logic rv,
                         input logic [31:0] rdata);
        bus.mem_valid             = v;
        bus.mem_rd                = rd;
        bus.mem_regfile_wr_enable = we;
        bus.mem_result_src        = src;
        bus.mem_funct3            = f3;
        bus.mem_alu_result        = alu;
        bus.mem_instr_addr_plus   = pc;
        bus.mem_lui_auipc_value   = lui;
        bus.dmem_rvalid           = rv;
        bus.dmem_rdata            = rdata;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 5'd0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    // Drive at the falling edge, then sample 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.wb_wr_addr !== 5'd0) begin n_bad++; $display("FAIL reset_addr got %h want 0", bus.wb_wr_addr); end
        n_cmp++; if (bus.wb_wr_data !== 32'd0) begin n_bad++; $display("FAIL reset_data got %h want 0", bus.wb_wr_data); end
        n_cmp++; if (bus.wb_regfile_wr_enable !== 1'b0) begin n_bad++; $display("FAIL reset_en got %b want 0", bus.wb_regfile_wr_enable); end
        n_cmp++; if (bus.wb_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", bus.wb_stall); end
        n_cmp++; if (bus.wb_load_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", bus.wb_load_err); end
        n_cmp++; if (bus.wb_retire_count !== 32'd0) begin n_bad++; $display("FAIL reset_count got %h want 0", bus.wb_retire_count); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        exp_count = 32'd0;
    endtask

    task automatic test_alu_path();
        @(negedge clk) drive(1'b1, 5'd5, 1'b1, 2'b00, 3'b010, 32'h1234, 32'h8, 32'h9, 1'b0, 32'h0);
        step(); exp_count = 32'd1;
        n_cmp++; if (bus.wb_regfile_wr_enable !== 1'b1) begin n_bad++; $display("FAIL alu_en got %b want 1", bus.wb_regfile_wr_enable); end
        n_cmp++; if (bus.wb_wr_addr !== 5'd5) begin n_bad++; $display("FAIL alu_addr got %0d want 5", bus.wb_wr_addr); end
        n_cmp++; if (bus.wb_wr_data !== 32'h1234) begin n_bad++; $display("FAIL alu_data got %h want 1234", bus.wb_wr_data); end
        n_cmp++; if (bus.wb_retire_count !== exp_count) begin n_bad++; $display("FAIL alu_count got %h want %h", bus.wb_retire_count, exp_count); end
        @(negedge clk) idle_inputs();
        step();
        n_cmp++; if (bus.wb_regfile_wr_enable !== 1'b0) begin n_bad++; $display("FAIL hold_en got %b want 0", bus.wb_regfile_wr_enable); end
        n_cmp++; if (bus.wb_wr_data !== 32'h1234 || bus.wb_wr_addr !== 5'd5) begin n_bad++; $display("FAIL hold_addr_data got %0d/%h want 5/1234", bus.wb_wr_addr, bus.wb_wr_data); end
        n_cmp++; if (bus.wb_retire_count !== exp_count) begin n_bad++; $display("FAIL hold_count got %h want %h", bus.wb_retire_count, exp_count); end
        @(negedge clk) drive(1'b1, 5'd7, 1'b1, 2'b11, 3'b000, 32'h11, 32'h22, 32'hABCD_E000, 1'b0, 32'h0);
        step(); exp_count = 32'd2;
        n_cmp++; if (bus.wb_wr_data !== 32'hABCD_E000 || bus.wb_wr_addr !== 5'd7) begin n_bad++; $display("FAIL lui_data got %0d/%h want 7/abcde000", bus.wb_wr_addr, bus.wb_wr_data); end
        @(negedge clk) drive(1'b1, 5'd8, 1'b1, 2'b10, 3'b000, 32'h11, 32'h44, 32'h33, 1'b0, 32'h0);
        step(); exp_count = 32'd3;
        n_cmp++; if (bus.wb_wr_data !== 32'h44 || bus.wb_regfile_wr_enable !== 1'b1) begin n_bad++; $display("FAIL pcplus_data got %h en %b want 44 en 1", bus.wb_wr_data, bus.wb_regfile_wr_enable); end
        n_cmp++; if (bus.wb_retire_count !== exp_count) begin n_bad++; $display("FAIL pcplus_count got %h want %h", bus.wb_retire_count, exp_count); end
        @(negedge clk) idle_inputs();
    endtask

    task automatic test_same_cycle_load();
        @(negedge clk) drive(1'b1, 5'd3, 1'b1, 2'b01, 3'b000, 32'h1003, 32'h0, 32'h0, 1'b1, 32'h80FF_FFFF);
        step(); exp_count = 32'd4;
        n_cmp++; if (bus.wb_wr_data !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_data got %h want ffffff80", bus.wb_wr_data); end
        n_cmp++; if (bus.wb_stall !== 1'b0 || bus.wb_regfile_wr_enable !== 1'b1) begin n_bad++; $display("FAIL lb_stall_en got %b/%b want 0/1", bus.wb_stall, bus.wb_regfile_wr_enable); end
        @(negedge clk) drive(1'b1, 5'd11, 1'b1, 2'b01, 3'b001, 32'h2002, 32'h0, 32'h0, 1'b1, 32'h8001_0000);
        step(); exp_count = 32'd5;
        n_cmp++; if (bus.wb_wr_data !== 32'hFFFF_8001 || bus.wb_wr_addr !== 5'd11) begin n_bad++; $display("FAIL lh_data got %0d/%h want 11/ffff8001", bus.wb_wr_addr, bus.wb_wr_data); end
        @(negedge clk) drive(1'b1, 5'd12, 1'b1, 2'b01, 3'b010, 32'h3001, 32'h0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        step(); exp_count = 32'd6;
        n_cmp++; if (bus.wb_wr_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL lw_data got %h want deadbeef", bus.wb_wr_data); end
        n_cmp++; if (bus.wb_retire_count !== exp_count) begin n_bad++; $display("FAIL load_count got %h want %h", bus.wb_retire_count, exp_count); end
        @(negedge clk) idle_inputs();
    endtask

    task automatic test_delayed_load();
        @(negedge clk) drive(1'b1, 5'd9, 1'b1, 2'b01, 3'b101, 32'h4002, 32'h0, 32'h0, 1'b0, 32'h0);
        step();
        n_cmp++; if (bus.wb_stall !== 1'b1 || bus.wb_regfile_wr_enable !== 1'b0) begin n_bad++; $display("FAIL dly_stall1 got %b en %b want 1 en 0", bus.wb_stall, bus.wb_regfile_wr_enable); end
        // Next instruction is held valid throughout the stall
        @(negedge clk) drive(1'b1, 5'd10, 1'b1, 2'b00, 3'b000, 32'h55, 32'h0, 32'h0, 1'b0, 32'h0);
        step();
        n_cmp++; if (bus.wb_stall !== 1'b1 || bus.wb_regfile_wr_enable !== 1'b0) begin n_bad++; $display("FAIL dly_stall2 got %b en %b want 1 en 0", bus.wb_stall, bus.wb_regfile_wr_enable); end
        step();
        n_cmp++; if (bus.wb_stall !== 1'b1 || bus.wb_regfile_wr_enable !== 1'b0) begin n_bad++; $display("FAIL dly_stall3 got %b en %b want 1 en 0", bus.wb_stall, bus.wb_regfile_wr_enable); end
        @(negedge clk) begin bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hBEEF_0000; end
        step(); exp_count = 32'd7;
        n_cmp++; if (bus.wb_wr_data !== 32'h0000_BEEF || bus.wb_wr_addr !== 5'd9) begin n_bad++; $display("FAIL dly_data got %0d/%h want 9/0000beef", bus.wb_wr_addr, bus.wb_wr_data); end
        n_cmp++; if (bus.wb_stall !== 1'b0 || bus.wb_regfile_wr_enable !== 1'b1) begin n_bad++; $display("FAIL dly_release got stall %b en %b want 0/1", bus.wb_stall, bus.wb_regfile_wr_enable); end
        @(negedge clk) begin bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'h0; end
        step(); exp_count = 32'd8;
        n_cmp++; if (bus.wb_wr_data !== 32'h55 || bus.wb_wr_addr !== 5'd10 || bus.wb_regfile_wr_enable !== 1'b1) begin n_bad++; $display("FAIL held_accept got %0d/%h en %b want 10/55 en 1", bus.wb_wr_addr, bus.wb_wr_data, bus.wb_regfile_wr_enable); end
        @(negedge clk) idle_inputs();
        step();
        n_cmp++; if (bus.wb_regfile_wr_enable !== 1'b0 || bus.wb_retire_count !== exp_count) begin n_bad++; $display("FAIL held_once got en %b count %h want 0/%h", bus.wb_regfile_wr_enable, bus.wb_retire_count, exp_count); end
    endtask

    task automatic test_no_write();
        @(negedge clk) drive(1'b1, 5'd0, 1'b1, 2'b10, 3'b000, 32'h0, 32'h104, 32'h0, 1'b0, 32'h0);
        step(); exp_count = 32'd9;
        n_cmp++; if (bus.wb_regfile_wr_enable !== 1'b0) begin n_bad++; $display("FAIL rd0_en got %b want 0", bus.wb_regfile_wr_enable); end
        n_cmp++; if (bus.wb_wr_data !== 32'h104 || bus.wb_wr_addr !== 5'd0) begin n_bad++; $display("FAIL rd0_data got %0d/%h want 0/104", bus.wb_wr_addr, bus.wb_wr_data); end
        n_cmp++; if (bus.wb_retire_count !== exp_count) begin n_bad++; $display("FAIL rd0_count got %h want %h", bus.wb_retire_count, exp_count); end
        // result_src=01 without a write is not a load and must not wait
        @(negedge clk) drive(1'b1, 5'd6, 1'b0, 2'b01, 3'b000, 32'h77, 32'h0, 32'h0, 1'b0, 32'h0);
        step(); exp_count = 32'd10;
        n_cmp++; if (bus.wb_regfile_wr_enable !== 1'b0 || bus.wb_wr_addr !== 5'd6 || bus.wb_stall !== 1'b0) begin n_bad++; $display("FAIL nowe got en %b addr %0d stall %b want 0/6/0", bus.wb_regfile_wr_enable, bus.wb_wr_addr, bus.wb_stall); end
        n_cmp++; if (bus.wb_retire_count !== exp_count) begin n_bad++; $display("FAIL nowe_count got %h want %h", bus.wb_retire_count, exp_count); end
        // Stray rvalid in IDLE with no load being accepted
        @(negedge clk) drive(1'b0, 5'd13, 1'b1, 2'b01, 3'b010, 32'h0, 32'h0, 32'h0, 1'b1, 32'h1234_5678);
        step();
        n_cmp++; if (bus.wb_regfile_wr_enable !== 1'b0 || bus.wb_wr_addr !== 5'd6 || bus.wb_retire_count !== exp_count) begin n_bad++; $display("FAIL stray_rvalid got en %b addr %0d count %h want 0/6/%h", bus.wb_regfile_wr_enable, bus.wb_wr_addr, bus.wb_retire_count, exp_count); end
        @(negedge clk) idle_inputs();
    endtask

    task automatic test_illegal_load();
        @(negedge clk) drive(1'b1, 5'd4, 1'b1, 2'b01, 3'b011, 32'h5000, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF);
        step(); exp_count = 32'd11;
        n_cmp++; if (bus.wb_wr_data !== 32'd0 || bus.wb_wr_addr !== 5'd4) begin n_bad++; $display("FAIL ill_data got %0d/%h want 4/0", bus.wb_wr_addr, bus.wb_wr_data); end
        n_cmp++; if (bus.wb_load_err !== 1'b1 || bus.wb_regfile_wr_enable !== 1'b1) begin n_bad++; $display("FAIL ill_err got %b en %b want 1/1", bus.wb_load_err, bus.wb_regfile_wr_enable); end
        @(negedge clk) idle_inputs();
        step();
        n_cmp++; if (bus.wb_load_err !== 1'b0) begin n_bad++; $display("FAIL ill_pulse got %b want 0", bus.wb_load_err); end
        n_cmp++; if (bus.wb_retire_count !== exp_count) begin n_bad++; $display("FAIL ill_count got %h want %h", bus.wb_retire_count, exp_count); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk) drive(1'b1, 5'd14, 1'b1, 2'b01, 3'b010, 32'h6000, 32'h0, 32'h0, 1'b0, 32'h0);
        step();
        n_cmp++; if (bus.wb_stall !== 1'b1) begin n_bad++; $display("FAIL rstmid_wait got %b want 1", bus.wb_stall); end
        @(negedge clk) idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.wb_stall !== 1'b0 || bus.wb_retire_count !== 32'd0) begin n_bad++; $display("FAIL rstmid_async got stall %b count %h want 0/0", bus.wb_stall, bus.wb_retire_count); end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) begin bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hCAFE_F00D; end
        step();
        step();
        n_cmp++; if (bus.wb_regfile_wr_enable !== 1'b0 || bus.wb_wr_data !== 32'd0 || bus.wb_wr_addr !== 5'd0) begin n_bad++; $display("FAIL rstmid_orphan got en %b %0d/%h want 0 0/0", bus.wb_regfile_wr_enable, bus.wb_wr_addr, bus.wb_wr_data); end
        n_cmp++; if (bus.wb_retire_count !== 32'd0 || bus.wb_stall !== 1'b0) begin n_bad++; $display("FAIL rstmid_count got %h stall %b want 0/0", bus.wb_retire_count, bus.wb_stall); end
        @(negedge clk) idle_inputs();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_count = 32'd0;
        test_reset();
        test_alu_path();
        test_same_cycle_load();
        test_delayed_load();
        test_no_write();
        test_illegal_load();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
